controller: RTL and testbench

Top-level controller for the stack calculator: debounces four push-buttons, executes push/pop/add/subtract on an 8-entry, 8-bit hardware stack loaded from the switches, and drives a 4-digit multiplexed seven-segment display with the top-of-stack value and the stack depth. It sits directly under the board top and connects to the raw button, switch and display pins. It is a single clock domain.

---
 rtl/controller.sv | 183 ++++++++++++++++++
 tb/tb_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Stack calculator top: debounced buttons push/pop/add/sub an 8-bit stack, shown on a 4-digit 7-seg display.
// Latency: press pulse 2+DEBOUNCE_CYCLES cycles after a clean raw edge; stack updates at the end of that cycle; segments one clock later.
// Backpressure: none; presses that do not fit the stack state (full, empty, fewer than two operands) are dropped.
module controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int DEPTH           = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ButtonUp_unfiltered,
  input  logic       ButtonDown_unfiltered,
  input  logic       ButtonLeft_unfiltered,
  input  logic       ButtonRight_unfiltered,
  input  logic [7:0] SWITCH,
  output logic [6:0] sevenSeg,
  output logic       anode0_controller,
  output logic       anode1_controller,
  output logic       anode2_controller,
  output logic       anode3_controller
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RFW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {OP_NONE, OP_PUSH, OP_POP, OP_ADD, OP_SUB} op_e;

  // bit0 = Up (push), bit1 = Down (pop), bit2 = Left (add), bit3 = Right (sub)
  logic [3:0]           w_raw;
  logic [3:0]           r_sync1, r_sync2;
  logic [3:0]           r_db, r_db_d;
  logic [3:0][DBW-1:0]  r_db_cnt;
  logic [3:0]           w_press;
  op_e                  w_op;

  logic [7:0]           r_mem [DEPTH];
  logic [CW-1:0]        r_count;
  logic [AW-1:0]        w_push_idx, w_top_idx, w_sec_idx;
  logic [7:0]           w_top_val;

  logic [RFW-1:0]       r_refresh;
  logic [1:0]           r_digit;
  logic [6:0]           w_seg_next;
  logic [3:0]           r_anode;
  logic [6:0]           r_seg;

  assign w_raw = {ButtonRight_unfiltered, ButtonLeft_unfiltered,
                  ButtonDown_unfiltered, ButtonUp_unfiltered};

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  // Two-flop synchronizer on the raw button pins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has disagreed with the current one for DEBOUNCE_CYCLES straight cycles; any agreement restarts the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_db     <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed debounced level so a held button yields a single rising-edge pulse.
  always_ff @(posedge CLK) begin
    if (RESET) r_db_d <= '0;
    else       r_db_d <= r_db;
  end

  assign w_press    = r_db & ~r_db_d;
  assign w_push_idx = r_count[AW-1:0];
  assign w_top_idx  = AW'(r_count - CW'(1));
  assign w_sec_idx  = AW'(r_count - CW'(2));

  // Pick the highest-priority press, then drop it if the stack cannot honour it.
  always_comb begin
    w_op = OP_NONE;
    if (w_press[0]) begin
      if (r_count < CW'(DEPTH)) w_op = OP_PUSH;
    end else if (w_press[1]) begin
      if (r_count != '0) w_op = OP_POP;
    end else if (w_press[2]) begin
      if (r_count >= CW'(2)) w_op = OP_ADD;
    end else if (w_press[3]) begin
      if (r_count >= CW'(2)) w_op = OP_SUB;
    end
  end

  // Stack storage; contents above the count are don't-care so no reset is needed.
  always_ff @(posedge CLK) begin
    case (w_op)
      OP_PUSH: r_mem[w_push_idx] <= SWITCH;
      OP_ADD:  r_mem[w_sec_idx]  <= r_mem[w_sec_idx] + r_mem[w_top_idx];
      OP_SUB:  r_mem[w_sec_idx]  <= r_mem[w_sec_idx] - r_mem[w_top_idx];
      default: ;
    endcase
  end

  // Stack depth: push grows it, pop and the binary ops shrink it by one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_PUSH:               r_count <= r_count + CW'(1);
        OP_POP, OP_ADD, OP_SUB: r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Scan timer: step to the next digit every REFRESH_CYCLES cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else if (r_refresh == RFW'(REFRESH_CYCLES - 1)) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    w_top_val  = (r_count == '0) ? 8'h00 : r_mem[w_top_idx];
    w_seg_next = 7'h7F;
    case (r_digit)
      2'd0:    w_seg_next = hex_font(w_top_val[3:0]);
      2'd1:    w_seg_next = hex_font(w_top_val[7:4]);
      2'd2:    w_seg_next = 7'h7F;
      default: w_seg_next = hex_font(4'(r_count));
    endcase
  end

  // Register anode and segments together so they always switch on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_anode <= 4'b1110;
      r_seg   <= 7'b1000000;
    end else begin
      r_anode <= ~(4'b0001 << r_digit);
      r_seg   <= w_seg_next;
    end
  end

  assign sevenSeg          = r_seg;
  assign anode0_controller = r_anode[0];
  assign anode1_controller = r_anode[1];
  assign anode2_controller = r_anode[2];
  assign anode3_controller = r_anode[3];
endmodule

// File: tb/tb_controller.sv
// Bench for controller: random and directed button presses against a queue-based stack model.
// Latency: each press is held long enough to debounce; the display is compared over a full scan afterwards.
// Backpressure: stimulus waits for the monitor to retire each expectation before the next press.
module tb_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       b_up, b_dn, b_lf, b_rt;
  logic [7:0] sw;
  logic [6:0] seg;
  logic       an0, an1, an2, an3;

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  int done     = 0;

  typedef struct {
    logic [3:0][6:0] segs;
    string           tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stk[$];

  always #5 clk = ~clk;

  controller #(
    .DEBOUNCE_CYCLES(4),
    .REFRESH_CYCLES (4),
    .DEPTH          (8)
  ) dut (
    .CLK                   (clk),
    .RESET                 (rst),
    .ButtonUp_unfiltered   (b_up),
    .ButtonDown_unfiltered (b_dn),
    .ButtonLeft_unfiltered (b_lf),
    .ButtonRight_unfiltered(b_rt),
    .SWITCH                (sw),
    .sevenSeg              (seg),
    .anode0_controller     (an0),
    .anode1_controller     (an1),
    .anode2_controller     (an2),
    .anode3_controller     (an3)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Reference stack: a plain queue, top at the back.
  function automatic void model_op(input logic [3:0] mask, input logic [7:0] swv);
    logic [7:0] a, b;
    if (mask[0]) begin
      if (stk.size() < 8) stk.push_back(swv);
    end else if (mask[1]) begin
      if (stk.size() > 0) void'(stk.pop_back());
    end else if (mask[2] || mask[3]) begin
      if (stk.size() >= 2) begin
        b = stk.pop_back();
        a = stk.pop_back();
        stk.push_back(mask[2] ? 8'(a + b) : 8'(a - b));
      end
    end
  endfunction

  function automatic logic [3:0][6:0] model_segs();
    logic [7:0]      top;
    logic [3:0][6:0] s;
    top  = (stk.size() > 0) ? stk[stk.size() - 1] : 8'h00;
    s[0] = font(top[3:0]);
    s[1] = font(top[7:4]);
    s[2] = 7'h7F;
    s[3] = font(4'(stk.size()));
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag);
    exp_t e;
    int   n;
    e.tag  = tag;
    e.segs = model_segs();
    exp_q.push_back(e);
    issued++;
    n = 0;
    while (done != issued && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done != issued) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor timeout, retired=%0d required=%0d", tag, done, issued);
      exp_q.delete();
      done = issued;
    end
    tick(1);
  endtask

  task automatic press(input logic [3:0] mask, input logic [7:0] swv, input int hold, input string tag);
    sw = swv;
    tick(1);
    {b_rt, b_lf, b_dn, b_up} = mask;
    tick(hold);
    {b_rt, b_lf, b_dn, b_up} = 4'b0000;
    tick(12);
    model_op(mask, swv);
    issue(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    checks++;
    if ({an3, an2, an1, an0} != 4'b1110 || seg != 7'b1000000) begin
      failures++;
      $display("FAIL %s: anodes=%b seg=%h required anodes=1110 seg=40", tag, {an3, an2, an1, an0}, seg);
    end
  endtask

  // Monitor: once an expectation is queued, capture one full scan and compare every digit.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && !rst) begin
        logic [3:0][6:0] got;
        logic [3:0]      seen;
        exp_t            e;
        got  = '0;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          case ({an3, an2, an1, an0})
            4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
            4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
            4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
            4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
            default: ;
          endcase
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int d = 0; d < 4; d++) begin
            checks++;
            if (!seen[d] || got[d] !== e.segs[d]) begin
              failures++;
              $display("FAIL %s digit%0d: seg=%h seen=%0b required seg=%h", e.tag, d, got[d], seen[d], e.segs[d]);
            end
          end
          done++;
        end
      end
    end
  end

  // Scan watcher: one anode low at a time, rotating 0->1->2->3, each lit REFRESH_CYCLES cycles.
  initial begin
    logic [3:0] prev_an, an;
    int         dwell;
    bit         first;
    prev_an = 4'b1110;
    dwell   = 0;
    first   = 1'b1;
    forever begin
      @(negedge clk);
      an = {an3, an2, an1, an0};
      if (rst) begin
        prev_an = 4'b1110;
        dwell   = 0;
        first   = 1'b1;
      end else begin
        checks++;
        if (!$onehot(~an)) begin
          failures++;
          $display("FAIL scan_onehot: anodes=%b required exactly one low", an);
        end
        if (an == prev_an) begin
          dwell++;
        end else begin
          checks++;
          if (an != {prev_an[2:0], prev_an[3]}) begin
            failures++;
            $display("FAIL scan_order: anodes=%b after %b required %b", an, prev_an, {prev_an[2:0], prev_an[3]});
          end
          if (!first) begin
            checks++;
            if (dwell != 4) begin
              failures++;
              $display("FAIL scan_dwell: digit lit %0d cycles required 4", dwell);
            end
          end
          first   = 1'b0;
          dwell   = 1;
          prev_an = an;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    rst = 1'b1;
    {b_rt, b_lf, b_dn, b_up} = 4'b0000;
    sw = 8'h00;
    tick(3);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    issue("reset_display");

    // Long hold gives exactly one push.
    press(4'b0001, 8'h3C, 100, "push_3C_hold");
    press(4'b0010, 8'h00, 12, "pop_to_empty");

    // Subtract wraps, add wraps.
    press(4'b0001, 8'h05, 12, "push_05");
    press(4'b0001, 8'h07, 12, "push_07");
    press(4'b1000, 8'h07, 12, "sub_FE");
    press(4'b0001, 8'h03, 12, "push_03");
    press(4'b0100, 8'h03, 12, "add_01");
    press(4'b0010, 8'h00, 12, "pop_empty");

    // Fill past capacity, then drain past empty.
    for (int i = 0; i < 9; i++) press(4'b0001, 8'(8'h10 + i * 8'h11), 12, "push_fill");
    for (int i = 0; i < 9; i++) press(4'b0010, 8'h00, 12, "pop_drain");

    // Simultaneous presses: push wins.
    press(4'b1111, 8'h11, 12, "all_buttons");

    // Bouncing input never settles long enough to count as a press.
    sw = 8'h99;
    b_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(2);
      b_up = ~b_up;
    end
    b_up = 1'b0;
    tick(12);
    issue("glitch_ignored");

    // Reset while Up is mid-debounce, keep holding through release.
    sw = 8'hA5;
    b_up = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset_mid_debounce");
    stk.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tick(12);
    b_up = 1'b0;
    tick(12);
    model_op(4'b0001, 8'hA5);
    issue("held_through_reset");

    // Randomised operations, mostly single buttons.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) m = 4'(1 << $urandom_range(0, 3));
      else                           m = 4'($urandom_range(1, 15));
      press(m, 8'($urandom), 10 + $urandom_range(0, 6), "random_op");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
